// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: request/status bundle between the board wrapper (master)
// and the CPU execution controller (slave).
interface cpu_run_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             run_req;
  logic             halt_req;
  logic             step_req;
  logic             cnt_clr;
  logic             bp_en;
  logic [31:0]      bp_inst;
  logic [31:0]      inst;
  logic             cpu_ce;
  logic [1:0]       state;
  logic [CNT_W-1:0] tick_cnt;
  logic             bp_hit;

  modport master (
    output run_req, halt_req, step_req, cnt_clr, bp_en, bp_inst, inst,
    input  cpu_ce, state, tick_cnt, bp_hit
  );

  modport slave (
    input  run_req, halt_req, step_req, cnt_clr, bp_en, bp_inst, inst,
    output cpu_ce, state, tick_cnt, bp_hit
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: generates a single-cycle CPU clock enable on the board clock
// with run / halt / single-step / instruction-breakpoint modes.
// Define RUN_CTRL_BP_EN to build the breakpoint compare and BREAK state;
// without it the breakpoint inputs are ignored and bp_hit is tied low.
module cpu_run_ctrl #(
  parameter int DIV_N = 500,
  parameter int CNT_W = 32
) (
  input logic           clk,
  input logic           rst,
  cpu_run_ctrl_if.slave bus
);

  localparam int DIV_W = (DIV_N > 1) ? $clog2(DIV_N) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_N - 1);

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BREAK = 2'b11
  } state_t;

  state_t           state_q;
  logic             ce_q;
  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] cnt_q;
  logic             bp_hit_q;
  logic             bp_skip_q;
  logic             tick_due;
  logic             bp_match;

  assign tick_due = (div_q == DIV_LAST);

`ifdef RUN_CTRL_BP_EN
  // bp_skip lets the CPU step off the instruction that caused the break.
  assign bp_match   = bus.bp_en && (bus.inst == bus.bp_inst) && !bp_skip_q;
  assign bus.bp_hit = bp_hit_q;
`else
  assign bp_match   = 1'b0;
  assign bus.bp_hit = 1'b0;
  logic unused_bp;
  assign unused_bp  = ^{bus.bp_en, bus.bp_inst, bus.inst, bp_hit_q, bp_skip_q};
`endif

  assign bus.cpu_ce   = ce_q;
  assign bus.state    = state_q;
  assign bus.tick_cnt = cnt_q;

  // Mode FSM with tick divider; cpu_ce is a registered one-cycle pulse.
  // NOTE: asynchronous reset sits in the sensitivity list so a reset mid-tick
  // kills a pending cpu_ce immediately, without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_HALT;
      ce_q      <= 1'b0;
      div_q     <= '0;
      bp_hit_q  <= 1'b0;
      bp_skip_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; the default below is
      // overridden later in the same block, and every read sees old values.
      ce_q <= 1'b0;
      unique case (state_q)
        ST_HALT, ST_BREAK: begin
          div_q <= '0;
          if (bus.halt_req) begin
            state_q  <= ST_HALT;
            bp_hit_q <= 1'b0;
          end else if (bus.step_req) begin
            state_q  <= ST_STEP;
            ce_q     <= 1'b1;
            bp_hit_q <= 1'b0;
          end else if (bus.run_req) begin
            state_q  <= ST_RUN;
            bp_hit_q <= 1'b0;
            if (state_q == ST_BREAK) bp_skip_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.halt_req) begin
            state_q <= ST_HALT;
            div_q   <= '0;
          end else if (tick_due) begin
            div_q <= '0;
            if (bp_match) begin
              state_q  <= ST_BREAK;
              bp_hit_q <= 1'b1;
            end else begin
              ce_q      <= 1'b1;
              bp_skip_q <= 1'b0;
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        ST_STEP: begin
          state_q <= ST_HALT;
        end
      endcase
    end
  end

  // Retired-tick counter; a clear wins over a same-edge increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      cnt_q <= '0;
    end else if (ce_q) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: table vectors, hand sequences for timing corners, and
// randomized traffic against a time-based reference model.
module tb_cpu_run_ctrl;

  localparam int DIV_A = 4;
  localparam int CNT_A = 4;
  localparam int DIV_B = 1;
  localparam int CNT_B = 8;
`ifdef RUN_CTRL_BP_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu_run_ctrl_if #(.CNT_W(CNT_A)) a ();
  cpu_run_ctrl_if #(.CNT_W(CNT_B)) b ();

  cpu_run_ctrl #(.DIV_N(DIV_A), .CNT_W(CNT_A)) dut_a (.clk(clk), .rst(rst), .bus(a));
  cpu_run_ctrl #(.DIV_N(DIV_B), .CNT_W(CNT_B)) dut_b (.clk(clk), .rst(rst), .bus(b));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    a.run_req = 0; a.halt_req = 0; a.step_req = 0; a.cnt_clr = 0;
    a.bp_en = 0; a.bp_inst = 32'h0; a.inst = 32'h0;
    b.run_req = 0; b.halt_req = 0; b.step_req = 0; b.cnt_clr = 0;
    b.bp_en = 0; b.bp_inst = 32'h0; b.inst = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One active edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: modes as plain integers (0 halt, 1 run, 2 step, 3 break);
  // a tick is due whenever a whole number of DIV_A periods has elapsed since RUN began.
  int          m_state, m_t0, m_n;
  bit          m_ce, m_hit, m_skip;
  int unsigned m_cnt;

  task automatic model_reset();
    m_state = 0; m_t0 = 0; m_n = 0;
    m_ce = 0; m_hit = 0; m_skip = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    bit nce;
    nce = 0;
    if (a.cnt_clr) m_cnt = 0;
    else if (m_ce) m_cnt = (m_cnt + 1) % (1 << CNT_A);
    case (m_state)
      0, 3: begin
        if (a.halt_req) begin
          m_state = 0; m_hit = 0;
        end else if (a.step_req) begin
          m_state = 2; nce = 1; m_hit = 0;
        end else if (a.run_req) begin
          if (m_state == 3) m_skip = 1;
          m_state = 1; m_t0 = m_n; m_hit = 0;
        end
      end
      1: begin
        if (a.halt_req) begin
          m_state = 0;
        end else if ((m_n - m_t0) % DIV_A == 0) begin
          if (BP && a.bp_en && a.inst == a.bp_inst && !m_skip) begin
            m_state = 3; m_hit = 1;
          end else begin
            nce = 1; m_skip = 0;
          end
        end
      end
      default: m_state = 0;
    endcase
    m_ce = nce;
    m_n++;
  endtask

  typedef struct {
    logic       run, halt, step, clr;
    logic [1:0] st;
    logic       ce;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl [18];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // run halt step clr | state ce cnt  (applied from reset, one row per edge)
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 4'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'd1};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'd1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 4'd1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 4'd1};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 4'd1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 4'd1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 4'd1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 4'd2};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 4'd2};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 4'd2};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 4'd2};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'd2};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 4'd2};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'd3};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 4'd3};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 4'd0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'd0};

    clear_inputs();
    @(negedge clk);
    check("reset state", a.state, 2'd0);
    check("reset ce", a.cpu_ce, 1'b0);
    check("reset cnt", a.tick_cnt, 4'd0);
    check("reset hit", a.bp_hit, 1'b0);
    do_reset();

    // Table vectors: step, run timing, priority, held step, clear vs increment.
    for (int i = 0; i < 18; i++) begin
      a.run_req = tbl[i].run; a.halt_req = tbl[i].halt;
      a.step_req = tbl[i].step; a.cnt_clr = tbl[i].clr;
      tick();
      check($sformatf("tbl%0d state", i), a.state, tbl[i].st);
      check($sformatf("tbl%0d ce", i), a.cpu_ce, tbl[i].ce);
      check($sformatf("tbl%0d cnt", i), a.tick_cnt, tbl[i].cnt);
    end
    clear_inputs();

    // Run from reset: pulses after edges 4, 8, 12; three counted by edge 13.
    do_reset();
    a.run_req = 1'b1;
    tick();
    a.run_req = 1'b0;
    check("run state", a.state, 2'd1);
    for (int k = 1; k <= 13; k++) begin
      tick();
      check($sformatf("run ce e%0d", k), a.cpu_ce, (k == 4 || k == 8 || k == 12));
    end
    check("run cnt", a.tick_cnt, 4'd3);

    // Breakpoint on the third due tick, then resume past it.
    do_reset();
    a.bp_en = 1'b1; a.bp_inst = 32'h00A3_0004; a.inst = 32'h1234_5678;
    a.run_req = 1'b1;
    tick();
    a.run_req = 1'b0;
    for (int k = 1; k <= 11; k++) tick();
    a.inst = 32'h00A3_0004;
    tick();
    check("bp state", a.state, BP ? 2'd3 : 2'd1);
    check("bp ce", a.cpu_ce, BP ? 1'b0 : 1'b1);
    check("bp hit", a.bp_hit, BP ? 1'b1 : 1'b0);
    a.run_req = 1'b1;
    tick();
    a.run_req = 1'b0;
    check("bp resume state", a.state, 2'd1);
    check("bp resume hit", a.bp_hit, 1'b0);
    for (int k = 14; k <= 17; k++) begin
      tick();
      check($sformatf("bp resume ce e%0d", k), a.cpu_ce, BP ? (k == 17) : (k == 16));
      check($sformatf("bp resume st e%0d", k), a.state, 2'd1);
    end
    check("bp cnt", a.tick_cnt, BP ? 4'd2 : 4'd4);
    clear_inputs();

    // Counter wrap: 17 single steps on a 4-bit counter leaves 1.
    do_reset();
    a.step_req = 1'b1;
    for (int k = 0; k <= 32; k++) tick();
    a.step_req = 1'b0;
    check("wrap last ce", a.cpu_ce, 1'b1);
    tick();
    check("wrap cnt", a.tick_cnt, 4'd1);

    // Asynchronous reset while a cpu_ce pulse is high.
    do_reset();
    a.run_req = 1'b1;
    tick();
    a.run_req = 1'b0;
    for (int k = 1; k <= 8; k++) tick();
    check("pre-rst ce", a.cpu_ce, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async rst ce", a.cpu_ce, 1'b0);
    check("async rst state", a.state, 2'd0);
    check("async rst cnt", a.tick_cnt, 4'd0);
    check("async rst hit", a.bp_hit, 1'b0);

    // DIV_N=1: continuous enable until halt.
    do_reset();
    b.run_req = 1'b1;
    tick();
    b.run_req = 1'b0;
    check("div1 ce e0", b.cpu_ce, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("div1 ce e%0d", k), b.cpu_ce, 1'b1);
      check($sformatf("div1 cnt e%0d", k), b.tick_cnt, 32'(k - 1));
    end
    b.halt_req = 1'b1;
    tick();
    b.halt_req = 1'b0;
    check("div1 halt ce", b.cpu_ce, 1'b0);
    check("div1 halt state", b.state, 2'd0);
    check("div1 halt cnt", b.tick_cnt, 8'd4);

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    a.bp_inst = 32'h00A3_0004;
    for (int i = 0; i < 3000; i++) begin
      a.halt_req = ($urandom_range(0, 15) == 0);
      a.step_req = ($urandom_range(0, 7) == 0);
      a.run_req  = ($urandom_range(0, 5) == 0);
      a.cnt_clr  = ($urandom_range(0, 31) == 0);
      a.bp_en    = ($urandom_range(0, 3) != 0);
      a.inst     = ($urandom_range(0, 2) == 0) ? a.bp_inst : $urandom;
      tick();
      model_step();
      check($sformatf("rand%0d state", i), a.state, m_state[1:0]);
      check($sformatf("rand%0d ce", i), a.cpu_ce, m_ce);
      check($sformatf("rand%0d cnt", i), a.tick_cnt, m_cnt[3:0]);
      check($sformatf("rand%0d hit", i), a.bp_hit, m_hit);
    end
    clear_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
